// File: rtl/flag_sync_pkg.sv
// flag_sync_pkg: shared constants and helpers for flag_sync_array.
// Holds the per-channel decode-mode encodings and prime-counter width.
package flag_sync_pkg;

   localparam logic FS_MODE_EDGE   = 1'b0;
   localparam logic FS_MODE_TOGGLE = 1'b1;

   // Wide enough to count 0..stages+1 inclusive.
   function automatic int primeW(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/flag_sync_chan.sv
// flag_sync_chan: one synchroniser channel with event decode and accounting.
// Ports: clk/rst, mode, primeDone, asyncIn, ack, clr -> level, flag, pending, overflow, count.
module flag_sync_chan
   import flag_sync_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             primeDone,
   input  logic             asyncIn,
   input  logic             ack,
   input  logic             clr,
   output logic             level,
   output logic             flag,
   output logic             pending,
   output logic             overflow,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] syncQ;

   logic hist;
   logic lvl;
   logic evt;

   assign lvl   = syncQ[STAGES-1];
   assign level = lvl;

   // Events are masked until the chain has flushed after reset.
   always_comb begin
      evt = 1'b0;
      if (primeDone) begin
         if (mode == FS_MODE_TOGGLE) evt = lvl ^ hist;
         else                        evt = lvl & ~hist;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         syncQ    <= '0;
         hist     <= 1'b0;
         flag     <= 1'b0;
         pending  <= 1'b0;
         overflow <= 1'b0;
         count    <= '0;
      end else begin
         syncQ <= {syncQ[STAGES-2:0], asyncIn};
         hist  <= lvl;
         flag  <= evt;
         if (clr) begin
            // Clear first, then account a coincident event.
            pending  <= evt;
            overflow <= 1'b0;
            count    <= evt ? CNT_W'(1) : '0;
         end else begin
            if (evt)      pending <= 1'b1;
            else if (ack) pending <= 1'b0;
            if (evt && pending && !ack) overflow <= 1'b1;
            if (evt && count != CNT_MAX) count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/flag_sync_array.sv
// flag_sync_array: multi-channel flag synchroniser with event accounting.
// Ports: clk, rst, async_i/ack_i/clr_i in; level_o, flag_o, pending_o, overflow_o, count_o out.
module flag_sync_array
   import flag_sync_pkg::*;
#(
   parameter int                  CHANNELS    = 4,
   parameter int                  STAGES      = 3,
   parameter logic [CHANNELS-1:0] TOGGLE_MASK = {CHANNELS{1'b1}},
   parameter int                  CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       async_i,
   input  logic [CHANNELS-1:0]       ack_i,
   input  logic [CHANNELS-1:0]       clr_i,
   output logic [CHANNELS-1:0]       level_o,
   output logic [CHANNELS-1:0]       flag_o,
   output logic [CHANNELS-1:0]       pending_o,
   output logic [CHANNELS-1:0]       overflow_o,
   output logic [CHANNELS*CNT_W-1:0] count_o
);

   localparam int            PW        = primeW(STAGES);
   localparam logic [PW-1:0] PRIME_END = PW'(STAGES + 1);

   logic [PW-1:0] primeCnt;
   logic          primeDone;

   // Counts STAGES+1 edges after reset so that levels already present
   // at the inputs settle through the chain without producing events.
   always_ff @(posedge clk) begin
      if (rst)             primeCnt <= '0;
      else if (!primeDone) primeCnt <= primeCnt + PW'(1);
   end

   assign primeDone = (primeCnt == PRIME_END);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      flag_sync_chan #(
         .STAGES (STAGES),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .mode      (TOGGLE_MASK[ch]),
         .primeDone (primeDone),
         .asyncIn   (async_i[ch]),
         .ack       (ack_i[ch]),
         .clr       (clr_i[ch]),
         .level     (level_o[ch]),
         .flag      (flag_o[ch]),
         .pending   (pending_o[ch]),
         .overflow  (overflow_o[ch]),
         .count     (count_o[ch*CNT_W +: CNT_W])
      );
   end

endmodule
